block_slider: RTL and testbench

Consumer of the 60 Hz `frame_tick` pulse produced by the frame delay counter. It turns frame ticks into paced horizontal motion of the active block row. After every `speed` frames it issues an erase request, then a redraw request, to the VGA draw datapath through a req/ack handshake, bouncing the block between screen bounds. A player `stop` latches the final position, which game logic reads for stacking.

---
 rtl/blockstacker_pkg.sv | 21 ++
 rtl/frame_step_counter.sv | 32 +++
 rtl/block_slider.sv | 159 +++++++++++++++
 tb/tb_block_slider.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blockstacker_pkg.sv
// Shared types and screen constants for the block stacker game logic.
package blockstacker_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BLOCK_W  = 16;

    localparam logic [2:0] COLOUR_BG    = 3'b000;
    localparam logic [2:0] COLOUR_BLOCK = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_DRAW,
        ST_WAIT,
        ST_ERASE,
        ST_MOVE,
        ST_DRAW,
        ST_LOCKED
    } slider_state_t;

endpackage

// File: rtl/frame_step_counter.sv
// Counts frame ticks while enabled and emits a one-cycle step pulse on the
// tick that brings the count to max(speed,1). Count restarts from zero on
// every step and whenever the clear is held.
module frame_step_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic [3:0] i_speed,
    output logic       o_step
);

    logic [3:0] r_count;
    logic [3:0] w_thresh_m1;

    // speed of 0 behaves as 1, so the step fires once count reaches thresh-1
    assign w_thresh_m1 = (i_speed == 4'd0) ? 4'd0 : (i_speed - 4'd1);
    assign o_step      = i_en && i_tick && (r_count >= w_thresh_m1);

    // Tick accumulator; a lowered speed is honoured on the next comparison
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_en && i_tick) begin
            r_count <= o_step ? 4'd0 : (r_count + 4'd1);
        end
    end

endmodule

// File: rtl/block_slider.sv
// Paces horizontal motion of the active block row from frame ticks and
// issues erase/redraw requests to the draw datapath over a req/ack handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | not running, waits for run
//   INIT_DRAW  | first draw of the block at X_MIN
//   WAIT       | counting frame ticks, acting on a pending stop
//   ERASE      | erase request at the old x
//   MOVE       | one-cycle position update with edge bounce
//   DRAW       | draw request at the new x
//   LOCKED     | block stopped, position held until run drops
module block_slider
    import blockstacker_pkg::*;
#(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int X_MIN = 0,
    parameter int X_MAX = 144,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          frame_tick,
    input  logic          run,
    input  logic [3:0]    speed,
    input  logic [YW-1:0] row_y,
    input  logic          stop,
    output logic          draw_req,
    output logic          draw_erase,
    output logic [XW-1:0] draw_x,
    output logic [YW-1:0] draw_y,
    input  logic          draw_ack,
    output logic [XW-1:0] x_pos,
    output logic          stopped,
    output logic          busy
);

    slider_state_t r_state;
    logic [XW-1:0] r_x_pos;
    logic [YW-1:0] r_y;
    logic          r_dir_right;
    logic          r_stop_pend;
    logic          r_draw_req;
    logic          r_draw_erase;
    logic [XW-1:0] r_draw_x;
    logic [YW-1:0] r_draw_y;
    logic          r_stopped;

    logic          w_in_wait;
    logic          w_step;
    logic [XW:0]   w_x_ext;

    assign w_in_wait = (r_state == ST_WAIT);
    assign w_x_ext   = {1'b0, r_x_pos};

    frame_step_counter u_step_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .i_en    (w_in_wait),
        .i_clear (!w_in_wait),
        .i_tick  (frame_tick),
        .i_speed (speed),
        .o_step  (w_step)
    );

    // Sequencer: handshakes, stop latching, abort and position update
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_x_pos      <= XW'(X_MIN);
            r_y          <= '0;
            r_dir_right  <= 1'b1;
            r_stop_pend  <= 1'b0;
            r_draw_req   <= 1'b0;
            r_draw_erase <= 1'b0;
            r_draw_x     <= '0;
            r_draw_y     <= '0;
            r_stopped    <= 1'b0;
        end else begin
            r_stopped <= 1'b0;
            if (stop && (r_state != ST_IDLE) && (r_state != ST_LOCKED)) begin
                r_stop_pend <= 1'b1;
            end
            if (!run && (r_state != ST_IDLE) && (r_state != ST_LOCKED)) begin
                // abandoned request: the datapath may still ack, which is ignored
                r_state    <= ST_IDLE;
                r_draw_req <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (run) begin
                            r_state     <= ST_INIT_DRAW;
                            r_y         <= row_y;
                            r_x_pos     <= XW'(X_MIN);
                            r_dir_right <= 1'b1;
                            r_stop_pend <= 1'b0;
                        end
                    end
                    ST_INIT_DRAW, ST_ERASE, ST_DRAW: begin
                        if (!r_draw_req) begin
                            r_draw_req   <= 1'b1;
                            r_draw_x     <= r_x_pos;
                            r_draw_y     <= r_y;
                            r_draw_erase <= (r_state == ST_ERASE);
                        end else if (draw_ack) begin
                            r_draw_req <= 1'b0;
                            r_state    <= (r_state == ST_ERASE) ? ST_MOVE : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // stop is only honoured here so the block is never left erased
                        if (r_stop_pend || stop) begin
                            r_state   <= ST_LOCKED;
                            r_stopped <= 1'b1;
                        end else if (w_step) begin
                            r_state <= ST_ERASE;
                        end
                    end
                    ST_MOVE: begin
                        if (r_dir_right) begin
                            if (w_x_ext + (XW+1)'(STEP) > (XW+1)'(X_MAX)) begin
                                r_dir_right <= 1'b0;
                                r_x_pos     <= r_x_pos - XW'(STEP);
                            end else begin
                                r_x_pos <= r_x_pos + XW'(STEP);
                            end
                        end else begin
                            if (w_x_ext < (XW+1)'(X_MIN) + (XW+1)'(STEP)) begin
                                r_dir_right <= 1'b1;
                                r_x_pos     <= r_x_pos + XW'(STEP);
                            end else begin
                                r_x_pos <= r_x_pos - XW'(STEP);
                            end
                        end
                        r_state <= ST_DRAW;
                    end
                    ST_LOCKED: begin
                        if (!run) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign draw_req   = r_draw_req;
    assign draw_erase = r_draw_erase;
    assign draw_x     = r_draw_x;
    assign draw_y     = r_draw_y;
    assign x_pos      = r_x_pos;
    assign stopped    = r_stopped;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_block_slider.sv
// Scoreboard bench for block_slider: stimulus pushes expected draw requests
// and stop pulses, a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_block_slider;

    localparam int K_REQ  = 0;
    localparam int K_STOP = 1;

    typedef struct {
        int   kind;
        logic erase;
        int   x;
        int   y;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       run;
    logic [3:0] speed;
    logic [6:0] row_y;
    logic       stop;
    logic       draw_req;
    logic       draw_erase;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic       draw_ack;
    logic [7:0] x_pos;
    logic       stopped;
    logic       busy;

    exp_t exp_q[$];
    int   total;
    int   passed;
    int   req_count;
    int   ack_delay;
    logic force_ack;

    // model of block position used to build expected requests
    int   mx;
    int   mdir_right;
    int   my;

    block_slider dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .run        (run),
        .speed      (speed),
        .row_y      (row_y),
        .stop       (stop),
        .draw_req   (draw_req),
        .draw_erase (draw_erase),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_ack   (draw_ack),
        .x_pos      (x_pos),
        .stopped    (stopped),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic push_req(input logic e, input int x, input int y);
        exp_t t;
        t.kind = K_REQ; t.erase = e; t.x = x; t.y = y;
        exp_q.push_back(t);
    endtask

    task automatic push_stop();
        exp_t t;
        t.kind = K_STOP; t.erase = 1'b0; t.x = 0; t.y = 0;
        exp_q.push_back(t);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     int'(draw_req),   0);
        check({tag, "_erase"},   int'(draw_erase), 0);
        check({tag, "_draw_x"},  int'(draw_x),     0);
        check({tag, "_draw_y"},  int'(draw_y),     0);
        check({tag, "_x_pos"},   int'(x_pos),      0);
        check({tag, "_stopped"}, int'(stopped),    0);
        check({tag, "_busy"},    int'(busy),       0);
    endtask

    // one paced step with speed 0: erase at old x, draw at bounced new x
    task automatic do_step();
        int nx;
        if (mdir_right != 0) begin
            if (mx + 1 > 144) begin mdir_right = 0; nx = mx - 1; end
            else nx = mx + 1;
        end else begin
            if (mx < 1) begin mdir_right = 1; nx = mx + 1; end
            else nx = mx - 1;
        end
        push_req(1'b1, mx, my);
        push_req(1'b0, nx, my);
        mx = nx;
        tick();
        cycles(30);
    endtask

    task automatic wait_req(input logic want_erase, input string name);
        int n;
        n = 0;
        while (!(draw_req && draw_erase == want_erase) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < 200) passed++;
        else $display("FAIL %s: no request within 200 cycles, required one", name);
    endtask

    // ack responder: ack_delay cycles after a request is seen, unless dropped
    initial begin
        int cnt;
        cnt = 0;
        draw_ack = 1'b0;
        forever begin
            @(negedge clk);
            draw_ack = 1'b0;
            if (force_ack) begin
                draw_ack = 1'b1;
            end else if (draw_req) begin
                if (cnt >= ack_delay) begin
                    draw_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor: pops expected events and checks request stability
    initial begin
        logic prev_req;
        logic cap_e;
        int   cap_x;
        int   cap_y;
        exp_t e;
        prev_req = 1'b0;
        cap_e = 1'b0; cap_x = 0; cap_y = 0;
        forever begin
            @(negedge clk);
            if (draw_req && !prev_req) begin
                req_count++;
                cap_e = draw_erase; cap_x = int'(draw_x); cap_y = int'(draw_y);
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_req: got erase=%0b x=%0d y=%0d, required no request",
                             draw_erase, draw_x, draw_y);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_REQ && e.erase == draw_erase && e.x == int'(draw_x) && e.y == int'(draw_y))
                        passed++;
                    else
                        $display("FAIL req: got kind=0 erase=%0b x=%0d y=%0d, required kind=%0d erase=%0b x=%0d y=%0d",
                                 draw_erase, draw_x, draw_y, e.kind, e.erase, e.x, e.y);
                end
            end else if (draw_req && prev_req) begin
                total++;
                if (cap_e == draw_erase && cap_x == int'(draw_x) && cap_y == int'(draw_y))
                    passed++;
                else
                    $display("FAIL req_stable: got erase=%0b x=%0d y=%0d, required erase=%0b x=%0d y=%0d",
                             draw_erase, draw_x, draw_y, cap_e, cap_x, cap_y);
            end
            if (stopped) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_stopped: got stopped=1, required 0");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_STOP) passed++;
                    else $display("FAIL stopped: got stopped pulse, required kind=%0d x=%0d", e.kind, e.x);
                end
            end
            prev_req = draw_req;
        end
    end

    initial begin
        int saved;
        total = 0; passed = 0; req_count = 0;
        ack_delay = 3; force_ack = 1'b0;
        resetn = 1'b0; run = 1'b0; frame_tick = 1'b0; stop = 1'b0;
        speed = 4'd4; row_y = 7'd0;
        cycles(3);
        check_reset_values("reset");
        @(negedge clk);
        resetn = 1'b1;
        cycles(2);

        // init draw at (0,100)
        row_y = 7'd100; my = 100; mx = 0; mdir_right = 1;
        push_req(1'b0, 0, 100);
        run = 1'b1;
        cycles(20);
        check("init_busy", int'(busy), 1);
        check("init_x_pos", int'(x_pos), 0);

        // speed 4: nothing until the 4th tick
        saved = req_count;
        repeat (3) begin tick(); cycles(20); end
        check("pace_no_req", req_count, saved);
        push_req(1'b1, 0, 100);
        push_req(1'b0, 1, 100);
        mx = 1;
        tick();
        cycles(30);
        check("pace_req_count", req_count, saved + 2);
        check("pace_x_pos", int'(x_pos), 1);

        // speed 0 behaves as 1
        speed = 4'd0;
        do_step();
        do_step();
        check("speed0_x_pos", int'(x_pos), 3);

        // bounce at right edge
        while (mx != 144) do_step();
        check("at_right_edge", int'(x_pos), 144);
        do_step();
        check("bounce_right", int'(x_pos), 143);

        // bounce at left edge
        while (mx != 0) do_step();
        check("at_left_edge", int'(x_pos), 0);
        do_step();
        check("bounce_left", int'(x_pos), 1);

        // stop while erase awaits ack: step completes, then lock
        ack_delay = 10;
        push_req(1'b1, 1, 100);
        push_req(1'b0, 2, 100);
        push_stop();
        tick();
        cycles(4);
        check("stop_in_erase", int'(draw_req && draw_erase), 1);
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        cycles(60);
        check("stop_x_pos", int'(x_pos), 2);
        saved = req_count;
        repeat (3) begin tick(); cycles(10); end
        check("locked_no_req", req_count, saved);
        check("locked_x_hold", int'(x_pos), 2);
        check("locked_busy", int'(busy), 1);
        run = 1'b0;
        cycles(2);
        check("unlock_busy", int'(busy), 0);

        // long ack: request held stable (monitor checks every cycle)
        ack_delay = 50;
        row_y = 7'd50; my = 50; mx = 0; mdir_right = 1;
        push_req(1'b0, 0, 50);
        run = 1'b1;
        cycles(30);
        check("long_ack_req_held", int'(draw_req), 1);
        cycles(50);
        check("long_ack_done", int'(draw_req), 0);

        // spurious ack in WAIT is ignored
        saved = req_count;
        @(posedge clk); force_ack = 1'b1;
        @(posedge clk); force_ack = 1'b0;
        cycles(5);
        check("spur_req", int'(draw_req), 0);
        check("spur_busy", int'(busy), 1);
        check("spur_reqs", req_count, saved);
        ack_delay = 3;
        do_step();
        check("spur_then_step", int'(x_pos), 1);

        // abort during DRAW
        ack_delay = 20;
        push_req(1'b1, 1, 50);
        push_req(1'b0, 2, 50);
        tick();
        wait_req(1'b0, "abort_wait_draw");
        run = 1'b0;
        @(negedge clk);
        check("abort_req", int'(draw_req), 0);
        check("abort_busy", int'(busy), 0);
        cycles(30);
        check("abort_stays_idle", int'(busy), 0);

        // reset mid-handshake
        push_req(1'b0, 0, 50);
        run = 1'b1;
        wait_req(1'b0, "rst_wait_req");
        resetn = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cycles(10);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
